envelope_shaper: RTL and testbench
==================================

# envelope_shaper

Per-sample ADSR amplitude stage sitting directly upstream of the I2S controller. It takes the raw square-wave sample stream from the oscillator, drives an attack/decay/sustain/release envelope from a note gate, and multiplies each sample by the envelope level. The result is the left/right sample word the I2S controller serialises. It runs on the slow audio clock and advances once per frame.

## Interface

Parameters:
- `SAMPLE_WIDTH`, 16: width of the signed sample in and out.
- `ENV_WIDTH`, 16: width of the unsigned envelope level. Full scale is all-ones.

Ports:
- `clk`, input, 1: audio clock (12.288 MHz domain). Single clock; no other clocks.
- `reset`, input, 1: asynchronous, active-low. Low clears all state immediately.
- `sample_tick`, input, 1: one-cycle strobe, once per audio frame. All envelope and sample updates happen only on cycles where it is high.
- `gate`, input, 1: note held. Level-sensitive and sampled only on ticks.
- `sample_in`, input, SAMPLE_WIDTH: signed two's-complement oscillator sample.
- `attack_step`, input, ENV_WIDTH: level increment per tick in ATTACK. 0 means instant.
- `decay_step`, input, ENV_WIDTH: level decrement per tick in DECAY. 0 means instant.
- `sustain_level`, input, ENV_WIDTH: hold level.
- `release_step`, input, ENV_WIDTH: level decrement per tick in RELEASE. 0 means instant.
- `sample_out`, output, SAMPLE_WIDTH: signed scaled sample, registered.
- `env_level`, output, ENV_WIDTH: current envelope level, registered.
- `state`, output, 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `busy`, output, 1: high whenever `state` is not IDLE (combinational from the state register).

## Operation

- **Reset values:** `state`=IDLE, `env_level`=0, `sample_out`=0, `busy`=0.
- **Non-tick cycles:** all registers hold.
- **On a tick, the FSM evaluates `gate` first, then the state's level rule.** Comparisons use the inputs as sampled on that tick.
- **IDLE:**
  - `gate`=1: go to ATTACK and apply the attack rule on this same tick.
  - Otherwise: `env_level` stays 0.
- **ATTACK:**
  - `gate`=0: go to RELEASE and apply the release rule this tick.
  - Otherwise, if `attack_step`=0 or `env_level`+`attack_step` ≥ 0xFFFF: set level to 0xFFFF and go to DECAY.
  - Otherwise: add `attack_step`, with the sum computed at ENV_WIDTH+1 bits.
- **DECAY:**
  - `gate`=0: go to RELEASE and apply the release rule this tick.
  - Otherwise, if `decay_step`=0 or `env_level` ≤ `sustain_level`+`decay_step`: set level to `sustain_level` and go to SUSTAIN. This also covers `sustain_level` > `env_level`.
  - Otherwise: subtract `decay_step`.
- **SUSTAIN:**
  - `gate`=0: go to RELEASE and apply the release rule this tick.
  - Otherwise: `env_level` = `sustain_level`, tracking live changes.
- **RELEASE:**
  - `gate`=1: retrigger. Go to ATTACK and apply the attack rule starting from the current level, with no jump to 0.
  - Otherwise, if `release_step`=0 or `env_level` ≤ `release_step`: set level to 0 and go to IDLE.
  - Otherwise: subtract `release_step`.
- **Scaling, computed on each tick:**
  - Form `sample_in` × {1'b0, `env_level`} as a signed product of SAMPLE_WIDTH+ENV_WIDTH+1 bits.
  - `sample_out` = product bits [SAMPLE_WIDTH+ENV_WIDTH-1 : ENV_WIDTH], i.e. an arithmetic shift right by ENV_WIDTH, which floors.
  - The multiply uses the pre-update `env_level`, so the sample path lags the envelope by one frame.
- **No overflow:** the magnitude of `sample_out` never exceeds the magnitude of `sample_in`.

## Timing

- **Latency:** `sample_out` and `env_level` change on the clock edge that samples `sample_tick`=1, and are visible the cycle after the tick. No multi-cycle path.
- **Holding between ticks:** outputs stay constant from tick to tick. The I2S controller may latch `sample_out` at any point between ticks.
- **Edge-sensitive only on ticks:** a `gate` pulse that starts and ends between two ticks is ignored.
- **Step inputs:** `*_step` and `sustain_level` may change on any cycle. Only their values on tick cycles matter.
- **Reset mid-operation:** asserting `reset` in any state forces the reset values asynchronously. On deassertion the block resumes in IDLE and the next tick is evaluated normally.
- **Consecutive ticks:** `sample_tick` high on back-to-back cycles is legal. Each high cycle is one full update.

## Test plan

- **Reset:** assert `reset`=0 mid-ATTACK with `env_level`=0x4000 → `state`=0, `env_level`=0, `sample_out`=0 and `busy`=0 within the same cycle, before any clock edge.
- **Full ADSR sequence:** `attack_step`=0x4000, `decay_step`=0x1000, `sustain_level`=0x8000, `release_step`=0x2000; hold `gate`=1.
  - Level over ticks: 0x4000, 0x8000, 0xC000, 0xFFFF (state now DECAY), 0xEFFF, … 0x8FFF, then 0x8000 with state SUSTAIN.
  - Drop `gate`: level goes 0x6000, 0x4000, 0x2000, 0x0000, with state IDLE on the last step.
- **Scaling extremes:**
  - `sample_in`=0x7FFF, `env_level`=0xFFFF → `sample_out`=0x7FFE.
  - `sample_in`=0x8000, `env_level`=0xFFFF → 0x8000.
  - `sample_in`=0x8000, `env_level`=0x8000 → 0xC000.
  - `env_level`=0 → 0x0000.
- **Zero steps:** `attack_step`=0 → level 0xFFFF and DECAY after one tick. `decay_step`=0 → `sustain_level` and SUSTAIN on the next tick. `release_step`=0 → 0 and IDLE on one tick.
- **Retrigger:** in RELEASE at 0x3000, raise `gate` with `attack_step`=0x1000 → next tick gives ATTACK with level 0x4000, not 0x1000.
- **Tick gating:** toggle `gate` and `sample_in` for 100 cycles with no `sample_tick` → all outputs unchanged. A gate pulse placed between ticks produces no state change.

Source files
------------

// File: rtl/envelope_shaper.sv
// ADSR envelope generator and sample scaler feeding the I2S controller.
// All state advances only on sample_tick; outputs are registered and hold between ticks.
module envelope_shaper #(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned ENV_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sample_tick,
   input  logic                    gate,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic [ENV_WIDTH-1:0]    attack_step,
   input  logic [ENV_WIDTH-1:0]    decay_step,
   input  logic [ENV_WIDTH-1:0]    sustain_level,
   input  logic [ENV_WIDTH-1:0]    release_step,
   output logic [SAMPLE_WIDTH-1:0] sample_out,
   output logic [ENV_WIDTH-1:0]    env_level,
   output logic [2:0]              state,
   output logic                    busy
);

   localparam int unsigned ProdWidth = SAMPLE_WIDTH + ENV_WIDTH + 1;
   localparam logic [ENV_WIDTH-1:0] EnvFull = '1;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StAttack  = 3'd1,
      StDecay   = 3'd2,
      StSustain = 3'd3,
      StRelease = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [ENV_WIDTH-1:0]    env_q, env_d;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;

   // Level rules, all evaluated from the current level so any state can borrow them.
   logic [ENV_WIDTH:0]   attack_sum;
   logic                 attack_done;
   logic [ENV_WIDTH-1:0] attack_level;
   state_e               attack_next;

   logic [ENV_WIDTH:0]   decay_floor;
   logic                 decay_done;

   logic                 release_done;
   logic [ENV_WIDTH-1:0] release_level;
   state_e               release_next;

   assign attack_sum   = {1'b0, env_q} + {1'b0, attack_step};
   assign attack_done  = (attack_step == '0) || (attack_sum >= {1'b0, EnvFull});
   assign attack_level = attack_done ? EnvFull : attack_sum[ENV_WIDTH-1:0];
   assign attack_next  = attack_done ? StDecay : StAttack;

   assign decay_floor  = {1'b0, sustain_level} + {1'b0, decay_step};
   assign decay_done   = (decay_step == '0) || ({1'b0, env_q} <= decay_floor);

   assign release_done  = (release_step == '0) || (env_q <= release_step);
   assign release_level = release_done ? '0 : (env_q - release_step);
   assign release_next  = release_done ? StIdle : StRelease;

   // Envelope is zero-extended so the product stays signed; result always fits.
   logic signed [ProdWidth-1:0] sample_ext, level_ext, product;
   logic                        unused_product_bits;

   assign sample_ext = {{(ENV_WIDTH + 1){sample_in[SAMPLE_WIDTH-1]}}, sample_in};
   assign level_ext  = {{(SAMPLE_WIDTH + 1){1'b0}}, env_q};
   assign product    = sample_ext * level_ext;
   assign unused_product_bits = ^{product[ProdWidth-1], product[ENV_WIDTH-1:0]};

   always_comb begin
      state_d  = state_q;
      env_d    = env_q;
      sample_d = sample_q;
      if (sample_tick) begin
         // Uses the pre-update level, so audio lags the envelope by one frame.
         sample_d = product[SAMPLE_WIDTH+ENV_WIDTH-1:ENV_WIDTH];
         unique case (state_q)
            StIdle: begin
               if (gate) begin
                  state_d = attack_next;
                  env_d   = attack_level;
               end else begin
                  env_d = '0;
               end
            end
            StAttack: begin
               if (!gate) begin
                  state_d = release_next;
                  env_d   = release_level;
               end else begin
                  state_d = attack_next;
                  env_d   = attack_level;
               end
            end
            StDecay: begin
               if (!gate) begin
                  state_d = release_next;
                  env_d   = release_level;
               end else if (decay_done) begin
                  state_d = StSustain;
                  env_d   = sustain_level;
               end else begin
                  env_d = env_q - decay_step;
               end
            end
            StSustain: begin
               if (!gate) begin
                  state_d = release_next;
                  env_d   = release_level;
               end else begin
                  env_d = sustain_level;
               end
            end
            StRelease: begin
               // Retrigger climbs from the current level rather than restarting at 0.
               if (gate) begin
                  state_d = attack_next;
                  env_d   = attack_level;
               end else begin
                  state_d = release_next;
                  env_d   = release_level;
               end
            end
            default: begin
               state_d = StIdle;
               env_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         env_q    <= '0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         env_q    <= env_d;
         sample_q <= sample_d;
      end
   end

   assign sample_out = sample_q;
   assign env_level  = env_q;
   assign state      = state_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed bench for envelope_shaper: ADSR walk, scaling extremes, zero steps,
// retrigger, tick gating and asynchronous reset.
module tb_envelope_shaper;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_tick;
   logic        gate;
   logic [15:0] sample_in;
   logic [15:0] attack_step;
   logic [15:0] decay_step;
   logic [15:0] sustain_level;
   logic [15:0] release_step;
   logic [15:0] sample_out;
   logic [15:0] env_level;
   logic [2:0]  state;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   localparam int Idle = 0, Attack = 1, Decay = 2, Sustain = 3, Release = 4;

   envelope_shaper #(
      .SAMPLE_WIDTH(16),
      .ENV_WIDTH   (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .gate         (gate),
      .sample_in    (sample_in),
      .attack_step  (attack_step),
      .decay_step   (decay_step),
      .sustain_level(sustain_level),
      .release_step (release_step),
      .sample_out   (sample_out),
      .env_level    (env_level),
      .state        (state),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Pulse sample_tick across one rising edge; returns at the following falling edge.
   task automatic tick();
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic check_env(input string tag, input logic [15:0] lvl, input int st);
      check({tag, " env"}, 32'(env_level), 32'(lvl));
      check({tag, " state"}, 32'(state), 32'(st));
   endtask

   initial begin
      reset         = 1'b0;
      sample_tick   = 1'b0;
      gate          = 1'b0;
      sample_in     = 16'h0000;
      attack_step   = 16'h0000;
      decay_step    = 16'h0000;
      sustain_level = 16'h0000;
      release_step  = 16'h0000;
      #2;
      check("reset state", 32'(state), 32'(Idle));
      check("reset env", 32'(env_level), 32'h0);
      check("reset out", 32'(sample_out), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Full ADSR walk
      sample_in     = 16'h7FFF;
      attack_step   = 16'h4000;
      decay_step    = 16'h1000;
      sustain_level = 16'h8000;
      release_step  = 16'h2000;
      gate          = 1'b1;
      tick();
      check_env("atk1", 16'h4000, Attack);
      check("atk1 out", 32'(sample_out), 32'h0000);
      check("atk1 busy", 32'(busy), 32'h1);
      tick();
      check_env("atk2", 16'h8000, Attack);
      check("atk2 out", 32'(sample_out), 32'h1FFF);
      tick();
      check_env("atk3", 16'hC000, Attack);
      tick();
      check_env("atk4", 16'hFFFF, Decay);
      for (int i = 1; i <= 7; i++) begin
         tick();
         check_env("decay", 16'(32'hFFFF - i * 32'h1000), Decay);
      end
      tick();
      check_env("to sustain", 16'h8000, Sustain);
      gate = 1'b0;
      tick();
      check_env("rel1", 16'h6000, Release);
      tick();
      check_env("rel2", 16'h4000, Release);
      tick();
      check_env("rel3", 16'h2000, Release);
      tick();
      check_env("rel4", 16'h0000, Idle);
      check("rel4 out", 32'(sample_out), 32'h0FFF);
      check("rel4 busy", 32'(busy), 32'h0);

      // Zero steps and scaling extremes
      attack_step   = 16'h0000;
      decay_step    = 16'h0000;
      sustain_level = 16'hFFFF;
      gate          = 1'b1;
      tick();
      check_env("zero atk", 16'hFFFF, Decay);
      tick();
      check_env("zero dec", 16'hFFFF, Sustain);
      check("scale 7fff x ffff", 32'(sample_out), 32'h7FFE);
      sample_in = 16'h8000;
      tick();
      check("scale 8000 x ffff", 32'(sample_out), 32'h8000);
      sustain_level = 16'h8000;
      tick();
      check_env("sustain track", 16'h8000, Sustain);
      tick();
      check("scale 8000 x 8000", 32'(sample_out), 32'hC000);
      release_step = 16'h0000;
      gate         = 1'b0;
      tick();
      check_env("zero rel", 16'h0000, Idle);
      tick();
      check("scale env 0", 32'(sample_out), 32'h0000);

      // Retrigger from RELEASE keeps the current level
      attack_step  = 16'h4000;
      release_step = 16'h1000;
      gate         = 1'b1;
      tick();
      check_env("rt atk", 16'h4000, Attack);
      gate = 1'b0;
      tick();
      check_env("rt rel", 16'h3000, Release);
      check("rt rel out", 32'(sample_out), 32'hE000);
      attack_step = 16'h1000;
      gate        = 1'b1;
      tick();
      check_env("retrigger", 16'h4000, Attack);
      check("retrigger out", 32'(sample_out), 32'hE800);

      // No tick: toggling inputs must not move anything
      for (int i = 0; i < 100; i++) begin
         gate      = ~gate;
         sample_in = 16'(i * 16'h0123);
         @(negedge clk);
      end
      check_env("no tick", 16'h4000, Attack);
      check("no tick out", 32'(sample_out), 32'hE800);

      sample_in    = 16'h8000;
      gate         = 1'b0;
      release_step = 16'h0000;
      tick();
      check_env("back idle", 16'h0000, Idle);
      gate = 1'b1;
      repeat (3) @(negedge clk);
      gate = 1'b0;
      @(negedge clk);
      tick();
      check_env("gate pulse", 16'h0000, Idle);
      check("gate pulse busy", 32'(busy), 32'h0);

      // Asynchronous reset mid-ATTACK, checked before the next clock edge
      attack_step = 16'h4000;
      gate        = 1'b1;
      tick();
      check_env("pre reset", 16'h4000, Attack);
      #1;
      reset = 1'b0;
      #1;
      check("async state", 32'(state), 32'(Idle));
      check("async env", 32'(env_level), 32'h0);
      check("async out", 32'(sample_out), 32'h0);
      check("async busy", 32'(busy), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      gate  = 1'b0;
      tick();
      check_env("post reset", 16'h0000, Idle);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
